// File: rtl/siso_frame_ctrl.sv
// -----------------------------------------------------------------------------
// siso_frame_ctrl
//
// Frame controller for an external serial-in/serial-out shift register of
// DEPTH stages. A WIDTH-bit word is accepted, shifted into the register MSB
// first, followed by DEPTH zero bits that push the tail of the word out. The
// bits leaving the register are collected into rx_data and compared against
// the transmitted word.
//
// Ports
//   clk         sole clock, rising edge
//   reset       asynchronous, active-high
//   load_valid  transmit word offered
//   load_ready  controller can accept a word
//   load_data   word to transmit
//   pause       stall request; freezes shifting while a frame is in flight
//   sr_en       shift enable to the SISO register
//   sr_din      bit driven into the register's serial_in
//   sr_dout     the register's serial_out
//   rx_data     word recovered from sr_dout (held until the next frame ends)
//   rx_valid    one-cycle pulse: rx_data and err are valid
//   err         recovered word differs from the transmitted word
// -----------------------------------------------------------------------------
module siso_frame_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             pause,
    output logic             sr_en,
    output logic             sr_din,
    input  logic             sr_dout,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             err
);

    // Frame-wide enable counter spans 0 .. WIDTH+DEPTH-1.
    localparam int CNT_W = $clog2(WIDTH + DEPTH);

    localparam logic [CNT_W-1:0] J_FIRST_RX   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] J_LAST_SHIFT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] J_LAST       = CNT_W'(WIDTH + DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FLUSH,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] j;
    logic [WIDTH-1:0] tx_word;   // latched copy used for the final compare
    logic [WIDTH-1:0] tx_shift;  // bits still to be presented on sr_din
    logic [WIDTH-1:0] rx_shift;
    logic [WIDTH-1:0] rx_next;
    logic             running;

    assign running = (state == SHIFT) || (state == FLUSH);

    // NOTE: sr_en is decoded from the registered state and the live pause
    // input so a stall takes effect in the very cycle it is requested.
    assign sr_en = running && !pause;

    assign rx_next = {rx_shift[WIDTH-2:0], sr_dout};

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            j          <= '0;
            tx_word    <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            load_ready <= 1'b0;
            sr_din     <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            err        <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            err      <= 1'b0;

            case (state)
                IDLE: begin
                    load_ready <= 1'b1;
                    if (load_ready && load_valid) begin
                        tx_word    <= load_data;
                        // MSB goes out on the first enabled cycle; the rest
                        // queue up behind it, zeros fill in for the flush.
                        sr_din     <= load_data[WIDTH-1];
                        tx_shift   <= {load_data[WIDTH-2:0], 1'b0};
                        j          <= '0;
                        load_ready <= 1'b0;
                        state      <= SHIFT;
                    end
                end

                SHIFT, FLUSH: begin
                    if (!pause) begin
                        j        <= j + 1'b1;
                        sr_din   <= tx_shift[WIDTH-1];
                        tx_shift <= tx_shift << 1;

                        // The first transmitted bit reaches sr_dout after
                        // DEPTH enabled edges.
                        if (j >= J_FIRST_RX) begin
                            rx_shift <= rx_next;
                        end

                        if (state == SHIFT && j == J_LAST_SHIFT) begin
                            state <= FLUSH;
                        end

                        if (state == FLUSH && j == J_LAST) begin
                            state    <= DONE;
                            j        <= '0;
                            rx_data  <= rx_next;
                            rx_valid <= 1'b1;
                            err      <= (rx_next != tx_word);
                        end
                    end
                end

                DONE: begin
                    state      <= IDLE;
                    load_ready <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_siso_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_siso_frame_ctrl
//
// Two controllers (DEPTH=4 and DEPTH=1, WIDTH=8), each attached to an ideal
// SISO register model. Frames are described by the transmitted word and a
// pause pattern; the expected serial stream, latency and recovered word follow
// directly from the frame rules.
// -----------------------------------------------------------------------------
module tb_siso_frame_ctrl;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       pause = 1'b0;
    bit         sel = 1'b0;    // 0: DEPTH=4 instance, 1: DEPTH=1 instance
    bit         stuck = 1'b0;  // force the register's serial_out to 0

    int n_checks = 0;
    int n_fail   = 0;

    bit plan_q[$];             // explicit pause pattern, one entry per busy cycle

    // DUT signals
    logic       a_lv, a_ready, a_en, a_din, a_dout, a_valid, a_err;
    logic [7:0] a_rx;
    logic       b_lv, b_ready, b_en, b_din, b_dout, b_valid, b_err;
    logic [7:0] b_rx;

    logic a_stage [4];
    logic b_stage [1];

    assign a_lv = load_valid & ~sel;
    assign b_lv = load_valid & sel;

    siso_frame_ctrl #(.WIDTH(8), .DEPTH(4)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .load_valid (a_lv),
        .load_ready (a_ready),
        .load_data  (load_data),
        .pause      (pause),
        .sr_en      (a_en),
        .sr_din     (a_din),
        .sr_dout    (a_dout),
        .rx_data    (a_rx),
        .rx_valid   (a_valid),
        .err        (a_err)
    );

    siso_frame_ctrl #(.WIDTH(8), .DEPTH(1)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .load_valid (b_lv),
        .load_ready (b_ready),
        .load_data  (load_data),
        .pause      (pause),
        .sr_en      (b_en),
        .sr_din     (b_din),
        .sr_dout    (b_dout),
        .rx_data    (b_rx),
        .rx_valid   (b_valid),
        .err        (b_err)
    );

    always #5 clk = ~clk;

    // Ideal SISO registers: shift on enabled edges, clear on reset.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) a_stage[i] <= 1'b0;
        end else if (a_en) begin
            for (int i = 3; i > 0; i--) a_stage[i] <= a_stage[i-1];
            a_stage[0] <= a_din;
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) b_stage[0] <= 1'b0;
        else if (b_en) b_stage[0] <= b_din;
    end

    assign a_dout = stuck ? 1'b0 : a_stage[3];
    assign b_dout = stuck ? 1'b0 : b_stage[0];

    // Observed outputs of the selected instance
    logic       o_ready, o_en, o_din, o_valid, o_err;
    logic [7:0] o_rx;
    assign o_ready = sel ? b_ready : a_ready;
    assign o_en    = sel ? b_en    : a_en;
    assign o_din   = sel ? b_din   : a_din;
    assign o_valid = sel ? b_valid : a_valid;
    assign o_err   = sel ? b_err   : a_err;
    assign o_rx    = sel ? b_rx    : a_rx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, o_ready, 1'b0);
        check({tag, "_sr_en"}, o_en, 1'b0);
        check({tag, "_sr_din"}, o_din, 1'b0);
        check({tag, "_valid"}, o_valid, 1'b0);
        check({tag, "_err"}, o_err, 1'b0);
        check({tag, "_rx"}, o_rx, 8'h00);
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!o_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("ready_wait", o_ready, 1'b1);
    endtask

    // Runs one frame on the selected instance. Starts and ends just after a
    // negedge. abort_at >= 0 returns (lat = -1) at the start of that busy cycle
    // so the caller can assert reset mid-frame.
    task automatic run_frame(input logic [7:0] word, input logic [7:0] next_data,
                             input bit keep_valid, input int pct,
                             input int abort_at, output int lat);
        int         total;
        int         en_cnt;
        int         run_cyc;
        int         t;
        bit         p;
        bit         got;
        bit         aborted;
        logic [7:0] sh;
        logic [7:0] exp_rx;

        total   = W + (sel ? 1 : 4);
        en_cnt  = 0;
        run_cyc = 0;
        got     = 1'b0;
        aborted = 1'b0;
        sh      = word;
        exp_rx  = stuck ? 8'h00 : word;
        lat     = -1;

        wait_ready();
        load_valid = 1'b1;
        load_data  = word;
        pause      = 1'($urandom_range(0, 1));  // must not block acceptance
        @(negedge clk);
        load_valid = keep_valid;
        load_data  = next_data;

        for (t = 1; t <= 80; t++) begin
            if (o_valid) begin
                got = 1'b1;
                break;
            end
            check("ready_busy", o_ready, 1'b0);
            check("err_idle", o_err, 1'b0);
            if (run_cyc == abort_at) begin
                aborted = 1'b1;
                break;
            end
            if (en_cnt < total) begin
                if (plan_q.size() > 0) p = plan_q.pop_front();
                else p = ($urandom_range(0, 99) < pct);
                pause = p;
                #1;
                check("sr_en", o_en, !p);
                check("sr_din", o_din, (en_cnt < W) ? sh[7] : 1'b0);
                if (!p) begin
                    en_cnt++;
                    sh = sh << 1;
                end
                run_cyc++;
            end else begin
                pause = 1'($urandom_range(0, 1));
                #1;
                check("sr_en_after", o_en, 1'b0);
            end
            @(negedge clk);
        end

        if (aborted) return;

        check("rx_seen", got, 1'b1);
        if (!got) return;

        lat = t;
        check("latency", t, run_cyc + 1);
        check("rx_data", o_rx, exp_rx);
        check("err", o_err, exp_rx != word);

        pause = 1'($urandom_range(0, 1));   // no effect during DONE
        @(negedge clk);
        check("valid_pulse", o_valid, 1'b0);
        check("err_clear", o_err, 1'b0);
        check("rx_hold", o_rx, exp_rx);
        check("ready_after", o_ready, 1'b1);
        pause = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;

        // Reset state
        @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;
        @(negedge clk);
        check("ready_first_a", o_ready, 1'b1);
        sel = 1'b1;
        #1;
        check("ready_first_b", o_ready, 1'b1);
        sel = 1'b0;

        // Basic frame
        run_frame(8'hA5, 8'h00, 1'b0, 0, -1, lat);
        check("lat_a5", lat, 13);

        // Serial output stuck at zero
        stuck = 1'b1;
        run_frame(8'h3C, 8'h00, 1'b0, 0, -1, lat);
        stuck = 1'b0;

        // Three pause cycles in SHIFT, two in FLUSH
        for (int i = 0; i < 2; i++) plan_q.push_back(1'b0);
        for (int i = 0; i < 3; i++) plan_q.push_back(1'b1);
        for (int i = 0; i < 7; i++) plan_q.push_back(1'b0);
        for (int i = 0; i < 2; i++) plan_q.push_back(1'b1);
        for (int i = 0; i < 3; i++) plan_q.push_back(1'b0);
        run_frame(8'hFF, 8'h00, 1'b0, 0, -1, lat);
        check("lat_paused", lat, 18);

        // load_valid held high across two frames
        run_frame(8'h01, 8'h80, 1'b1, 0, -1, lat);
        check("accept_gap", lat + 1, 14);
        run_frame(8'h80, 8'h00, 1'b0, 0, -1, lat);
        check("lat_80", lat, 13);

        // Reset in the 5th SHIFT cycle
        run_frame(8'hA5, 8'h00, 1'b0, 0, 4, lat);
        reset      = 1'b1;
        load_valid = 1'b0;
        pause      = 1'b0;
        #1;
        check_reset_values("abort");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_abort", o_ready, 1'b1);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("no_valid_abandoned", o_valid, 1'b0);
        end
        run_frame(8'h5A, 8'h00, 1'b0, 0, -1, lat);
        check("lat_5a", lat, 13);

        // DEPTH=1 instance
        sel = 1'b1;
        run_frame(8'h81, 8'h00, 1'b0, 0, -1, lat);
        check("lat_d1", lat, 10);
        sel = 1'b0;

        // Randomized frames on both instances
        for (int i = 0; i < 30; i++) begin
            sel   = ($urandom_range(0, 3) == 0);
            stuck = ($urandom_range(0, 7) == 0);
            run_frame(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 50), -1, lat);
        end
        stuck      = 1'b0;
        load_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
